fleet_placement_ctrl: RTL and testbench

// - Sequences the 8x8 cell memory through the game: idle -> fleet placement -> shooting.
// - Drives the memory's play_status, dimension, direction, we and new_value; consumes its ship_placed pulse.
// - Walks a fixed fleet list, one ship per accepted click; right button rotates the ship; rejected drops retry.
// - Sits between the mouse/button front end and the cell memory, in the core clock domain.

---
 rtl/fleet_placement_ctrl_pkg.sv | 28 ++
 rtl/fleet_placement_ctrl_if.sv | 20 ++
 rtl/fleet_placement_ctrl_btn_edge_sync.sv | 23 ++
 rtl/fleet_placement_ctrl.sv | 147 ++++++++++++++
 tb/tb_fleet_placement_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fleet_placement_ctrl_pkg.sv
// Shared codes for the placement controller and the 8x8 cell memory it drives.
package fleet_placement_ctrl_pkg;

  localparam logic [1:0] PS_IDLE  = 2'd0;
  localparam logic [1:0] PS_PLACE = 2'd1;
  localparam logic [1:0] PS_SHOOT = 2'd2;

  localparam logic [3:0] CELL_EMPTY             = 4'd0;
  localparam logic [3:0] CELL_PREVIEW_OVER_SHIP = 4'd1;
  localparam logic [3:0] CELL_SHIP              = 4'd4;
  localparam logic [3:0] CELL_HIT               = 4'd5;
  localparam logic [3:0] CELL_PREVIEW           = 4'd7;
  localparam logic [3:0] CELL_INVALID           = 4'd10;

  // Ship 0 sits in bits [3:0]: the default fleet places lengths 4,3,3,2,2.
  localparam int         NUM_SHIPS_DEFAULT = 5;
  localparam logic [19:0] FLEET_DEFAULT    = {4'd2, 4'd2, 4'd3, 4'd3, 4'd4};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREVIEW = 3'd1,
    ST_COMMIT  = 3'd2,
    ST_ACK     = 3'd3,
    ST_NEXT    = 3'd4,
    ST_SHOOT   = 3'd5
  } fsm_state_t;

endpackage

// File: rtl/fleet_placement_ctrl_if.sv
// Controller <-> cell memory bus. we is a full-cycle level; the memory writes on the
// negedge inside it and answers with a one-cycle ship_placed pulse.
interface fleet_placement_ctrl_if;
  logic [1:0] play_status;
  logic [3:0] dimension;
  logic       direction;
  logic       we;
  logic [3:0] new_value;
  logic       ship_placed;

  modport master (
    output play_status, dimension, direction, we, new_value,
    input  ship_placed
  );

  modport slave (
    input  play_status, dimension, direction, we, new_value,
    output ship_placed
  );
endinterface

// File: rtl/fleet_placement_ctrl_btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button level plus a rising-edge pulse.
module btn_edge_sync (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= btn;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign pulse = s2_q & ~prev_q;
endmodule

// File: rtl/fleet_placement_ctrl.sv
// Game sequencer: idle -> fleet placement (preview/commit/ack per ship) -> shooting.
// All outputs are registered from the next-state decode.
module fleet_placement_ctrl
  import fleet_placement_ctrl_pkg::*;
#(
  parameter int                         NUM_SHIPS  = NUM_SHIPS_DEFAULT,
  parameter logic [4*NUM_SHIPS-1:0]     FLEET      = FLEET_DEFAULT,
  parameter int                         ACK_WAIT   = 2,
  parameter logic [3:0]                 SHOT_VALUE = CELL_HIT
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  click,
  input  logic                  rotate,
  fleet_placement_ctrl_if.master mem,
  output logic [2:0]            ship_idx,
  output logic                  reject,
  output logic                  fleet_done,
  output fsm_state_t            state_dbg
);
  localparam int              CW       = $clog2(ACK_WAIT + 1);
  localparam logic [CW-1:0]   ACK_MAX  = CW'(ACK_WAIT);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_SHIPS - 1);

  logic start_p, abort_p, click_p, rotate_p;

  btn_edge_sync u_start  (.clk_in(clk_in), .rst_n(rst_n), .btn(start),  .pulse(start_p));
  btn_edge_sync u_abort  (.clk_in(clk_in), .rst_n(rst_n), .btn(abort),  .pulse(abort_p));
  btn_edge_sync u_click  (.clk_in(clk_in), .rst_n(rst_n), .btn(click),  .pulse(click_p));
  btn_edge_sync u_rotate (.clk_in(clk_in), .rst_n(rst_n), .btn(rotate), .pulse(rotate_p));

  fsm_state_t    state_q, state_n;
  logic [2:0]    idx_q, idx_n;
  logic          dir_q, dir_n;
  logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
  logic [1:0]    ps_q, ps_n;
  logic [3:0]    dim_q, dim_n, nv_q, nv_n;
  logic          we_q, we_n, rej_q, rej_n, done_q, done_n, shot;

  function automatic logic [3:0] fleet_len(input logic [2:0] i);
    fleet_len = 4'd0;
    for (int k = 0; k < NUM_SHIPS; k++)
      if (i == 3'(k)) fleet_len = FLEET[4*k +: 4];
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      ps_q    <= PS_IDLE;
      dim_q   <= '0;
      we_q    <= 1'b0;
      nv_q    <= '0;
      rej_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      dir_q   <= dir_n;
      cnt_q   <= cnt_n;
      ps_q    <= ps_n;
      dim_q   <= dim_n;
      we_q    <= we_n;
      nv_q    <= nv_n;
      rej_q   <= rej_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    dir_n   = dir_q;
    cnt_n   = cnt_q;
    rej_n   = 1'b0;
    shot    = 1'b0;
    cnt_inc = (cnt_q == ACK_MAX) ? cnt_q : cnt_q + 1'b1;

    if (abort_p) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      dir_n   = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_p) begin
          state_n = ST_PREVIEW;
          idx_n   = '0;
          dir_n   = 1'b0;
        end
        // Rotate wins over a same-cycle click so a commit never uses a stale direction.
        ST_PREVIEW: begin
          if (rotate_p)     dir_n   = ~dir_q;
          else if (click_p) state_n = ST_COMMIT;
        end
        ST_COMMIT: begin
          state_n = ST_ACK;
          cnt_n   = '0;
        end
        ST_ACK: begin
          if (mem.ship_placed) begin
            state_n = ST_NEXT;
          end else if (cnt_inc == ACK_MAX) begin
            state_n = ST_PREVIEW;
            rej_n   = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) state_n = ST_SHOOT;
          else begin
            state_n = ST_PREVIEW;
            idx_n   = idx_q + 3'd1;
          end
        end
        ST_SHOOT: shot = click_p;
        default:  state_n = ST_IDLE;
      endcase
    end

    case (state_n)
      ST_IDLE:  ps_n = PS_IDLE;
      ST_SHOOT: ps_n = PS_SHOOT;
      default:  ps_n = PS_PLACE;
    endcase
    dim_n  = (state_n == ST_IDLE || state_n == ST_SHOOT) ? 4'd0 : fleet_len(idx_n);
    we_n   = (state_n == ST_COMMIT) || shot;
    nv_n   = shot ? SHOT_VALUE : 4'd0;
    done_n = (state_n == ST_SHOOT);
  end

  assign mem.play_status = ps_q;
  assign mem.dimension   = dim_q;
  assign mem.direction   = dir_q;
  assign mem.we          = we_q;
  assign mem.new_value   = nv_q;
  assign ship_idx        = idx_q;
  assign reject          = rej_q;
  assign fleet_done      = done_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_fleet_placement_ctrl.sv
// Directed bench for fleet_placement_ctrl: placement, reject, rotate, shooting and abort.
module tb_fleet_placement_ctrl;
  import fleet_placement_ctrl_pkg::*;

  logic clk_in, rst_n, start, abort, click, rotate;
  logic [2:0] ship_idx;
  logic reject, fleet_done;
  fsm_state_t state_dbg;
  int checks = 0;
  int failures = 0;

  fleet_placement_ctrl_if mem_if ();

  fleet_placement_ctrl dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort),
    .click(click), .rotate(rotate), .mem(mem_if.master),
    .ship_idx(ship_idx), .reject(reject), .fleet_done(fleet_done),
    .state_dbg(state_dbg)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; abort = 0; click = 0; rotate = 0; mem_if.ship_placed = 0;
    tick(2);
    checks++;
    if ({mem_if.play_status, mem_if.dimension, mem_if.direction, mem_if.we, mem_if.new_value,
         ship_idx, reject, fleet_done} !== 20'd0) begin
      failures++;
      $display("FAIL reset_outputs got ps=%0d dim=%0d dir=%0d we=%0d nv=%0d idx=%0d rej=%0d done=%0d want all 0",
               mem_if.play_status, mem_if.dimension, mem_if.direction, mem_if.we,
               mem_if.new_value, ship_idx, reject, fleet_done);
    end
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (state_dbg !== ST_IDLE || mem_if.play_status !== 2'd0) begin
      failures++;
      $display("FAIL reset_idle got state=%0d ps=%0d want state=0 ps=0", state_dbg, mem_if.play_status);
    end
  endtask

  task automatic test_start;
    start = 1;
    tick(2);
    checks++;
    if (mem_if.play_status !== 2'd0) begin
      failures++;
      $display("FAIL start_latency got ps=%0d after 2 edges want 0", mem_if.play_status);
    end
    tick(1);
    checks++;
    if (mem_if.play_status !== 2'd1 || ship_idx !== 3'd0 || mem_if.dimension !== 4'd4 ||
        mem_if.direction !== 1'b0 || mem_if.we !== 1'b0) begin
      failures++;
      $display("FAIL start_preview got ps=%0d idx=%0d dim=%0d dir=%0d we=%0d want 1 0 4 0 0",
               mem_if.play_status, ship_idx, mem_if.dimension, mem_if.direction, mem_if.we);
    end
    start = 0;
    tick(3);
    start = 1;
    tick(4);
    checks++;
    if (state_dbg !== ST_PREVIEW || ship_idx !== 3'd0) begin
      failures++;
      $display("FAIL start_ignored got state=%0d idx=%0d want 1 0", state_dbg, ship_idx);
    end
    start = 0;
    tick(2);
  endtask

  task automatic test_rotate;
    int we_seen;
    rotate = 1;
    tick(3);
    checks++;
    if (mem_if.direction !== 1'b1 || mem_if.we !== 1'b0) begin
      failures++;
      $display("FAIL rotate_toggle got dir=%0d we=%0d want 1 0", mem_if.direction, mem_if.we);
    end
    rotate = 0;
    tick(3);
    click = 1; rotate = 1;
    we_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (mem_if.we === 1'b1) we_seen++;
    end
    checks++;
    if (mem_if.direction !== 1'b0 || we_seen != 0 || state_dbg !== ST_PREVIEW) begin
      failures++;
      $display("FAIL click_rotate_same got dir=%0d we_pulses=%0d state=%0d want 0 0 1",
               mem_if.direction, we_seen, state_dbg);
    end
    click = 0; rotate = 0;
    tick(3);
  endtask

  task automatic test_reject;
    rotate = 1;
    tick(3);
    rotate = 0;
    tick(3);
    click = 1;
    tick(3);
    checks++;
    if (mem_if.we !== 1'b1 || state_dbg !== ST_COMMIT) begin
      failures++;
      $display("FAIL reject_commit got we=%0d state=%0d want 1 2", mem_if.we, state_dbg);
    end
    click = 0;
    tick(2);
    checks++;
    if (reject !== 1'b0 || mem_if.we !== 1'b0 || state_dbg !== ST_ACK) begin
      failures++;
      $display("FAIL reject_early got rej=%0d we=%0d state=%0d want 0 0 3", reject, mem_if.we, state_dbg);
    end
    tick(1);
    checks++;
    if (reject !== 1'b1 || state_dbg !== ST_PREVIEW || ship_idx !== 3'd0 ||
        mem_if.direction !== 1'b1 || mem_if.we !== 1'b0) begin
      failures++;
      $display("FAIL reject_pulse got rej=%0d state=%0d idx=%0d dir=%0d we=%0d want 1 1 0 1 0",
               reject, state_dbg, ship_idx, mem_if.direction, mem_if.we);
    end
    tick(1);
    checks++;
    if (reject !== 1'b0 || mem_if.we !== 1'b0) begin
      failures++;
      $display("FAIL reject_one_cycle got rej=%0d we=%0d want 0 0", reject, mem_if.we);
    end
    tick(3);
  endtask

  task automatic test_place_fleet;
    logic [3:0] dim_tab [5];
    dim_tab = '{4'd4, 4'd3, 4'd3, 4'd2, 4'd2};
    for (int i = 0; i < 5; i++) begin
      click = 1;
      tick(3);
      checks++;
      if (mem_if.we !== 1'b1 || mem_if.dimension !== dim_tab[i]) begin
        failures++;
        $display("FAIL place_commit[%0d] got we=%0d dim=%0d want 1 %0d", i, mem_if.we, mem_if.dimension, dim_tab[i]);
      end
      click = 0;
      tick(1);
      mem_if.ship_placed = 1;
      tick(1);
      mem_if.ship_placed = 0;
      checks++;
      if (mem_if.we !== 1'b0 || state_dbg !== ST_NEXT || ship_idx !== 3'(i)) begin
        failures++;
        $display("FAIL place_next[%0d] got we=%0d state=%0d idx=%0d want 0 4 %0d", i, mem_if.we, state_dbg, ship_idx, i);
      end
      tick(1);
      if (i < 4) begin
        checks++;
        if (state_dbg !== ST_PREVIEW || ship_idx !== 3'(i + 1) || mem_if.dimension !== dim_tab[i+1]) begin
          failures++;
          $display("FAIL place_advance[%0d] got state=%0d idx=%0d dim=%0d want 1 %0d %0d",
                   i, state_dbg, ship_idx, mem_if.dimension, i + 1, dim_tab[i+1]);
        end
      end else begin
        checks++;
        if (mem_if.play_status !== 2'd2 || fleet_done !== 1'b1 || mem_if.dimension !== 4'd0 ||
            ship_idx !== 3'd4) begin
          failures++;
          $display("FAIL fleet_complete got ps=%0d done=%0d dim=%0d idx=%0d want 2 1 0 4",
                   mem_if.play_status, fleet_done, mem_if.dimension, ship_idx);
        end
      end
      tick(2);
    end
  endtask

  task automatic test_shoot;
    int we_seen;
    click = 1;
    tick(3);
    checks++;
    if (mem_if.we !== 1'b1 || mem_if.new_value !== 4'd5) begin
      failures++;
      $display("FAIL shoot_first got we=%0d nv=%0d want 1 5", mem_if.we, mem_if.new_value);
    end
    rotate = 1;
    we_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (mem_if.we === 1'b1 || mem_if.new_value !== 4'd0) we_seen++;
    end
    checks++;
    if (we_seen != 0 || mem_if.direction !== 1'b1 || state_dbg !== ST_SHOOT) begin
      failures++;
      $display("FAIL shoot_held got extra_writes=%0d dir=%0d state=%0d want 0 1 5", we_seen, mem_if.direction, state_dbg);
    end
    click = 0; rotate = 0;
    tick(3);
    click = 1;
    tick(3);
    checks++;
    if (mem_if.we !== 1'b1 || mem_if.new_value !== 4'd5) begin
      failures++;
      $display("FAIL shoot_second got we=%0d nv=%0d want 1 5", mem_if.we, mem_if.new_value);
    end
    click = 0;
    tick(1);
    checks++;
    if (mem_if.we !== 1'b0 || mem_if.new_value !== 4'd0 || mem_if.play_status !== 2'd2) begin
      failures++;
      $display("FAIL shoot_end got we=%0d nv=%0d ps=%0d want 0 0 2", mem_if.we, mem_if.new_value, mem_if.play_status);
    end
    tick(2);
  endtask

  task automatic test_abort;
    abort = 1;
    tick(3);
    checks++;
    if (state_dbg !== ST_IDLE || mem_if.play_status !== 2'd0 || fleet_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_shoot got state=%0d ps=%0d done=%0d want 0 0 0", state_dbg, mem_if.play_status, fleet_done);
    end
    abort = 0;
    tick(2);
    start = 1;
    tick(3);
    start = 0;
    click = 1;
    tick(2);
    abort = 1;
    tick(1);
    checks++;
    if (mem_if.we !== 1'b1 || state_dbg !== ST_COMMIT) begin
      failures++;
      $display("FAIL abort_setup got we=%0d state=%0d want 1 2", mem_if.we, state_dbg);
    end
    click = 0;
    tick(1);
    mem_if.ship_placed = 1;
    tick(1);
    mem_if.ship_placed = 0;
    checks++;
    if (state_dbg !== ST_IDLE ||
        {mem_if.play_status, mem_if.dimension, mem_if.direction, mem_if.we, mem_if.new_value,
         ship_idx, reject, fleet_done} !== 20'd0) begin
      failures++;
      $display("FAIL abort_in_ack got state=%0d ps=%0d dim=%0d dir=%0d we=%0d nv=%0d idx=%0d rej=%0d done=%0d want all 0",
               state_dbg, mem_if.play_status, mem_if.dimension, mem_if.direction, mem_if.we,
               mem_if.new_value, ship_idx, reject, fleet_done);
    end
    abort = 0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_start();
    test_rotate();
    test_reject();
    test_place_fleet();
    test_shoot();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
